// File: rtl/and_or_pipe.sv
// and_or_pipe: selectable AND/OR logic function feeding a valid/ready register pipeline with transfer counters
module and_or_pipe #(
    parameter int W = 8,
    parameter int STAGES = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic [W-1:0]     d,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     f,
    input  logic             clr,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [CNT_W-1:0] hit_cnt
);
    logic [W-1:0] fn;
    logic [STAGES-1:0] v, ld, nv;
    logic [W-1:0] dat [STAGES];
    logic [W-1:0] nd [STAGES];
    logic xfer;
    always_comb fn = mode == 2'd0 ? (a & b) | (c & d) :
                     mode == 2'd1 ? (a | b) & (c | d) :
                     mode == 2'd2 ? (a ^ b) | (c ^ d) : ~((a & b) | (c & d));
    always_comb begin
        nv = STAGES'({v, in_valid});
        nd[0] = fn;
        for (int k = 1; k < STAGES; k++)
            nd[k] = dat[k-1];
        for (int k = 0; k < STAGES; k++)
            ld[k] = out_ready | ~&(v | STAGES'((1 << k) - 1));
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            v <= '0;
            for (int k = 0; k < STAGES; k++)
                dat[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++)
                if (ld[k]) begin
                    v[k] <= nv[k];
                    if (nv[k])
                        dat[k] <= nd[k];
                end
        end
    assign xfer = v[STAGES-1] & out_ready;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            xfer_cnt <= '0;
            hit_cnt <= '0;
        end else if (clr) begin
            xfer_cnt <= '0;
            hit_cnt <= '0;
        end else if (xfer) begin
            if (xfer_cnt != '1)
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            if (dat[STAGES-1] == '1 && hit_cnt != '1)
                hit_cnt <= hit_cnt + CNT_W'(1);
        end
    assign in_ready = ld[0];
    assign out_valid = v[STAGES-1];
    assign f = dat[STAGES-1];
endmodule

// File: tb/tb_and_or_pipe.sv
// tb_and_or_pipe: randomized and directed checks of and_or_pipe at STAGES 1, 2 and 4
module tb_and_or_pipe;
    logic clk = 0;
    logic rst = 1;
    logic in_valid = 0, out_ready = 0, clr = 0;
    logic [1:0] mode = 0;
    logic [7:0] a = 0, b = 0, c = 0, d = 0;
    logic ir0, ir1, ir2, ov0, ov1, ov2;
    logic [7:0] f0, f1, f2;
    logic [15:0] xc0, hc0, xc1, hc1;
    logic [3:0] xc2, hc2;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    and_or_pipe #(.W(8), .STAGES(2), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
        .a(a), .b(b), .c(c), .d(d), .mode(mode), .out_valid(ov0), .out_ready(out_ready), .f(f0), .clr(clr),
        .xfer_cnt(xc0), .hit_cnt(hc0));
    and_or_pipe #(.W(8), .STAGES(1), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
        .a(a), .b(b), .c(c), .d(d), .mode(mode), .out_valid(ov1), .out_ready(out_ready), .f(f1), .clr(clr),
        .xfer_cnt(xc1), .hit_cnt(hc1));
    and_or_pipe #(.W(8), .STAGES(4), .CNT_W(4)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
        .a(a), .b(b), .c(c), .d(d), .mode(mode), .out_valid(ov2), .out_ready(out_ready), .f(f2), .clr(clr),
        .xfer_cnt(xc2), .hit_cnt(hc2));

    function automatic int st(int i); return i == 0 ? 2 : i == 1 ? 1 : 4; endfunction
    function automatic int cmax(int i); return i == 2 ? 15 : 65535; endfunction
    function automatic logic gir(int i); return i == 0 ? ir0 : i == 1 ? ir1 : ir2; endfunction
    function automatic logic gov(int i); return i == 0 ? ov0 : i == 1 ? ov1 : ov2; endfunction
    function automatic logic [7:0] gf(int i); return i == 0 ? f0 : i == 1 ? f1 : f2; endfunction
    function automatic int gxc(int i); return i == 0 ? int'(xc0) : i == 1 ? int'(xc1) : int'(xc2); endfunction
    function automatic int ghc(int i); return i == 0 ? int'(hc0) : i == 1 ? int'(hc1) : int'(hc2); endfunction

    function automatic logic [7:0] ref_f(logic [1:0] m, logic [7:0] p, logic [7:0] q, logic [7:0] r, logic [7:0] s);
        case (m)
            2'd0: return (p & q) | (r & s);
            2'd1: return (p | q) & (r | s);
            2'd2: return (p ^ q) | (r ^ s);
            default: return ~((p & q) | (r & s));
        endcase
    endfunction

    function automatic logic [7:0] rnd_op();
        return ($urandom % 4 == 0) ? 8'hFF : 8'($urandom);
    endfunction

    task automatic do_reset();
        in_valid = 0; out_ready = 0; clr = 0;
        rst = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
    endtask

    task automatic test_reset();
        #1 rst = 0;
        #2;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (gov(i) !== 1'b0 || gf(i) !== 8'h00 || gxc(i) != 0 || ghc(i) != 0 || gir(i) !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_state u%0d: ov=%b f=%h xc=%0d hc=%0d ir=%b, want ov=0 f=00 xc=0 hc=0 ir=1",
                         i, gov(i), gf(i), gxc(i), ghc(i), gir(i));
            end
        end
        @(posedge clk);
        #1 rst = 1;
    endtask

    task automatic test_basic();
        do_reset();
        mode = 2'd0; a = 8'hF0; b = 8'hFF; c = 8'h0F; d = 8'h0F;
        in_valid = 1; out_ready = 1;
        #1;
        n_cmp++;
        if (ir0 !== 1'b1) begin n_bad++; $display("FAIL basic_in_ready: got %b want 1", ir0); end
        @(posedge clk); #1 in_valid = 0;
        n_cmp++;
        if (ov0 !== 1'b0) begin n_bad++; $display("FAIL basic_early: out_valid=%b after 1 cycle want 0", ov0); end
        @(posedge clk); #1;
        n_cmp++;
        if (ov0 !== 1'b1 || f0 !== 8'hFF) begin
            n_bad++; $display("FAIL basic_result: ov=%b f=%h want ov=1 f=ff", ov0, f0);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (hc0 !== 16'd1 || xc0 !== 16'd1 || ov0 !== 1'b0) begin
            n_bad++; $display("FAIL basic_counts: hc=%0d xc=%0d ov=%b want 1 1 0", hc0, xc0, ov0);
        end
    endtask

    task automatic test_modes();
        logic [7:0] e [4] = '{8'h88, 8'hEE, 8'hFF, 8'h77};
        do_reset();
        a = 8'hAA; b = 8'hCC; c = 8'hF0; d = 8'h0F; out_ready = 1;
        for (int t = 0; t < 9; t++) begin
            for (int i = 0; i < 3; i++)
                if (t >= st(i) && t < st(i) + 4) begin
                    n_cmp++;
                    if (gov(i) !== 1'b1 || gf(i) !== e[t - st(i)]) begin
                        n_bad++; $display("FAIL mode_%0d u%0d: ov=%b f=%h want ov=1 f=%h",
                                          t - st(i), i, gov(i), gf(i), e[t - st(i)]);
                    end
                end
            in_valid = t < 4;
            mode = 2'(t);
            #1;
            if (t < 4) begin
                n_cmp++;
                if ({ir0, ir1, ir2} !== 3'b111) begin
                    n_bad++; $display("FAIL mode_throughput t=%0d: in_ready=%b want 111", t, {ir0, ir1, ir2});
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        logic [7:0] q[$];
        int sent = 0, rcv = 0, blocked = 0;
        bit ps = 0;
        logic [7:0] pf = 0;
        do_reset();
        for (int cyc = 0; cyc < 80 && rcv < 10; cyc++) begin
            in_valid = sent < 10;
            mode = 2'($urandom); a = rnd_op(); b = rnd_op(); c = rnd_op(); d = rnd_op();
            out_ready = rcv < 1 || cyc >= 12;
            #1;
            n_cmp++;
            if (ir0 !== (q.size() < 2 || out_ready)) begin
                n_bad++; $display("FAIL stall_in_ready cyc=%0d: got %b want %b", cyc, ir0, q.size() < 2 || out_ready);
            end
            if (!ir0) blocked++;
            if (ps) begin
                n_cmp++;
                if (ov0 !== 1'b1 || f0 !== pf) begin
                    n_bad++; $display("FAIL stall_hold cyc=%0d: ov=%b f=%h want ov=1 f=%h", cyc, ov0, f0, pf);
                end
            end
            if (ov0 && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL stall_order cyc=%0d: got f=%h want no output", cyc, f0);
                end else if (f0 !== q[0]) begin
                    n_bad++; $display("FAIL stall_order cyc=%0d: got f=%h want %h", cyc, f0, q[0]);
                end
                if (q.size() != 0) void'(q.pop_front());
                rcv++;
            end
            if (in_valid && ir0) begin q.push_back(ref_f(mode, a, b, c, d)); sent++; end
            ps = ov0 && !out_ready;
            pf = f0;
            @(posedge clk); #1;
        end
        in_valid = 0;
        n_cmp++;
        if (rcv != 10 || xc0 !== 16'd10 || blocked == 0) begin
            n_bad++; $display("FAIL stall_total: rcv=%0d xc=%0d blocked=%0d want 10 10 >0", rcv, xc0, blocked);
        end
    endtask

    task automatic test_saturate();
        int waited = 0;
        do_reset();
        mode = 2'd0; a = 8'hFF; b = 8'hFF; c = 8'h00; d = 8'h00; out_ready = 1; in_valid = 1;
        repeat (20) @(posedge clk);
        #1 in_valid = 0;
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (xc2 !== 4'hF || hc2 !== 4'hF || xc0 !== 16'd20) begin
            n_bad++; $display("FAIL sat_counts: xc2=%h hc2=%h xc0=%0d want F F 20", xc2, hc2, xc0);
        end
        in_valid = 1;
        @(posedge clk); #1 in_valid = 0;
        while (!ov2 && waited < 10) begin @(posedge clk); #1; waited++; end
        n_cmp++;
        if (ov2 !== 1'b1) begin n_bad++; $display("FAIL sat_wait: ov2=%b want 1 within 10 cycles", ov2); end
        clr = 1;
        @(posedge clk); #1 clr = 0;
        n_cmp++;
        if (xc2 !== 4'h0 || hc2 !== 4'h0 || xc0 !== 16'd0 || ov2 !== 1'b0) begin
            n_bad++; $display("FAIL sat_clr: xc2=%h hc2=%h xc0=%0d ov2=%b want 0 0 0 0", xc2, hc2, xc0, ov2);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        mode = 2'd0; a = 8'hFF; b = 8'hFF; c = 8'h00; d = 8'h00;
        in_valid = 1; out_ready = 1;
        repeat (3) @(posedge clk);
        #1 out_ready = 0;
        repeat (4) @(posedge clk);
        #1 in_valid = 0;
        n_cmp++;
        if (ov0 !== 1'b1 || xc0 == 16'd0 || ir0 !== 1'b0) begin
            n_bad++; $display("FAIL areset_pre: ov=%b xc=%0d ir=%b want 1 >0 0", ov0, xc0, ir0);
        end
        #2 rst = 0;
        #1;
        n_cmp++;
        if (ov0 !== 1'b0 || f0 !== 8'h00 || xc0 !== 16'd0 || hc0 !== 16'd0 || ir0 !== 1'b1) begin
            n_bad++; $display("FAIL areset_now: ov=%b f=%h xc=%0d hc=%0d ir=%b want 0 00 0 0 1", ov0, f0, xc0, hc0, ir0);
        end
        @(posedge clk); #1 rst = 1; out_ready = 1;
        for (int t = 0; t < 5; t++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (ov0 !== 1'b0 || ov2 !== 1'b0) begin
                n_bad++; $display("FAIL areset_stale t=%0d: ov0=%b ov2=%b want 0 0", t, ov0, ov2);
            end
        end
    endtask

    task automatic test_random(int i);
        logic [7:0] q[$];
        int xm = 0, hm = 0;
        bit ps = 0, xf;
        logic [7:0] pf = 0;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid = $urandom % 10 < 6;
            out_ready = $urandom % 2 == 0;
            clr = $urandom % 30 == 0;
            mode = 2'($urandom); a = rnd_op(); b = rnd_op(); c = rnd_op(); d = rnd_op();
            #1;
            n_cmp++;
            if (gir(i) !== (q.size() < st(i) || out_ready)) begin
                n_bad++; $display("FAIL rand%0d_in_ready cyc=%0d: got %b want %b", i, cyc, gir(i), q.size() < st(i) || out_ready);
            end
            if (ps) begin
                n_cmp++;
                if (gov(i) !== 1'b1 || gf(i) !== pf) begin
                    n_bad++; $display("FAIL rand%0d_hold cyc=%0d: ov=%b f=%h want ov=1 f=%h", i, cyc, gov(i), gf(i), pf);
                end
            end
            n_cmp++;
            if (gxc(i) != xm || ghc(i) != hm) begin
                n_bad++; $display("FAIL rand%0d_cnt cyc=%0d: xc=%0d hc=%0d want %0d %0d", i, cyc, gxc(i), ghc(i), xm, hm);
            end
            xf = gov(i) && out_ready;
            if (xf) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL rand%0d_data cyc=%0d: got f=%h want no output", i, cyc, gf(i));
                end else if (gf(i) !== q[0]) begin
                    n_bad++; $display("FAIL rand%0d_data cyc=%0d: got f=%h want %h", i, cyc, gf(i), q[0]);
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            if (clr) begin xm = 0; hm = 0; end
            else if (xf) begin
                xm = xm < cmax(i) ? xm + 1 : xm;
                if (gf(i) == 8'hFF) hm = hm < cmax(i) ? hm + 1 : hm;
            end
            if (in_valid && gir(i)) q.push_back(ref_f(mode, a, b, c, d));
            ps = gov(i) && !out_ready;
            pf = gf(i);
            @(posedge clk); #1;
        end
        in_valid = 0; clr = 0; out_ready = 1;
        for (int t = 0; t < 8; t++) begin
            #1;
            if (gov(i)) begin
                n_cmp++;
                if (q.size() == 0 || gf(i) !== q[0]) begin
                    n_bad++; $display("FAIL rand%0d_drain: got f=%h want %h (pending %0d)", i, gf(i),
                                      q.size() ? q[0] : 8'h00, q.size());
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (q.size() != 0 || gov(i) !== 1'b0) begin
            n_bad++; $display("FAIL rand%0d_loss: %0d results missing, ov=%b want 0 0", i, q.size(), gov(i));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_modes();
        test_stall();
        test_saturate();
        test_async_reset();
        for (int i = 0; i < 3; i++) test_random(i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/and_or_pipe.md
AND_OR_PIPE -- requirements
Module: and_or_pipe

Interface
REQ-001 Parameter: W, 8, operand/result width in bits (1..32).
REQ-002 Parameter: STAGES, 2, pipeline depth in register stages (1..4).
REQ-003 Parameter: CNT_W, 16, width of transfer counter (4..32).
REQ-004 Port: clk  input  1  clock, all state on rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-low.
REQ-006 Port: in_valid  input  1  operand set present.
REQ-007 Port: in_ready  output  1  block accepts operand set this cycle.
REQ-008 Port: a, b, c, d  input  W each  operands.
REQ-009 Port: mode  input  2  logic function, sampled with operands.
REQ-010 Port: out_valid  output  1  result present.
REQ-011 Port: out_ready  input  1  downstream accepts result.
REQ-012 Port: f  output  W  registered result.
REQ-013 Port: clr  input  1  synchronous counter clear.
REQ-014 Port: xfer_cnt  output  CNT_W  saturating count of output transfers.
REQ-015 Port: hit_cnt  output  CNT_W  saturating count of output transfers with f all-ones.

Function
REQ-016 Input transfer SHALL occur when in_valid & in_ready; output transfer when out_valid & out_ready.
REQ-017 mode 00: f = (a&b)|(c&d); 01: (a|b)&(c|d); 10: (a^b)|(c^d); 11: ~((a&b)|(c&d)); bitwise over W.
REQ-018 Function SHALL be evaluated combinationally before stage 0 and registered; stages 1..STAGES-1 are pass-through registers.
REQ-019 Each stage k SHALL hold valid bit v[k] and W-bit data; stage k loads when v[k]=0 or stage k advances.
REQ-020 Stage STAGES-1 advances on output transfer; stage k<STAGES-1 advances when stage k+1 loads.
REQ-021 in_ready SHALL equal ~v[0] | (stage 0 advancing); combinational from out_ready allowed.
REQ-022 out_valid SHALL equal v[STAGES-1]; f SHALL equal data of stage STAGES-1.
REQ-023 Latency: result of an accepted set SHALL appear on f with out_valid exactly STAGES cycles after acceptance when out_ready held 1.
REQ-024 Throughput: one transfer per cycle sustained with out_ready=1; no bubbles inserted.
REQ-025 With out_ready=0, pipeline SHALL fill to STAGES entries, then in_ready=0; no data lost, duplicated or reordered.
REQ-026 f and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 Stage data SHALL not change when its valid bit is 0 and not loading (no spurious toggling).
REQ-028 xfer_cnt SHALL increment by 1 per output transfer, saturating at 2^CNT_W-1 (no wrap).
REQ-029 hit_cnt SHALL increment per output transfer with f = all-ones, saturating likewise.
REQ-030 clr=1 SHALL zero both counters next edge; clr has priority over a simultaneous transfer (that transfer not counted).
REQ-031 clr SHALL not affect pipeline contents or handshakes.

Reset
REQ-032 On rst=0, immediately and independent of clk: all v[k]=0, all stage data=0, f=0, out_valid=0, xfer_cnt=0, hit_cnt=0.
REQ-033 in_ready SHALL be 1 during and after reset; in-flight data is discarded on reset mid-operation.
REQ-034 First input transfer possible on first rising edge after rst deasserts.

Verification
REQ-035 W=8, STAGES=2, out_ready=1, mode=00, a=F0 b=FF c=0F d=0F -> f=FF, out_valid=1 exactly 2 cycles later, hit_cnt=1.
REQ-036 All four modes with a=AA b=CC c=F0 d=0F -> f=88|00=88, EE&FF=EE, 66|FF=FF, 77.
REQ-037 Stream 10 sets, out_ready=0 after 1 result -> in_ready=0 after 2 entries held, release: all 10 results in order, xfer_cnt=10.
REQ-038 CNT_W=4, 20 transfers -> xfer_cnt saturates at F; clr with simultaneous transfer -> xfer_cnt=0.
REQ-039 rst asserted between clock edges with 2 entries in flight -> out_valid=0, f=0, counters 0 immediately; no stale output after release.
REQ-040 Random in_valid/out_ready, STAGES=1 and 4 -> scoreboard matches reference model, no loss/dup, f stable under stall.
